// File: rtl/peak_dpu_de_dp_pipe.sv
// Purpose : DP decode stage. Decodes RV32C/RV32I (and RV32M when M_EXT=1) data-processing
//           instructions into the issue bundle and queues DEPTH bundles in program order.
// Latency : 1 cycle. A bundle pushed at edge N into an empty queue is presented after edge N.
// Backpr. : in_rdy = (count < DEPTH) from registered state only. When the queue is full, a
//           same-cycle pop does not free a slot for a push.
// Ports   : clk/rst (async, active-high), flush; in_vld/in_rdy/in_is_compressed/in_op on the
//           fetch side; dp_vld/dp_rdy plus decoded bundle (rd_r0_*, rd_r1_*, wr_*, imm, use_imm,
//           is_alu/is_mul/is_div, alu_op/mul_op/div_op) on the issue side.
// Option  : PEAK_DPU_DE_DP_ILLEGAL_EN adds the per-entry `illegal` output (in_op all-zero,
//           all-ones, c.addi4spn imm=0, c.lui imm=0); flagged entries carry no unit select.
module peak_dpu_de_dp_pipe #(
    parameter int DEPTH = 2,
    parameter int M_EXT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic        in_is_compressed,
    input  logic [31:0] in_op,
`ifdef PEAK_DPU_DE_DP_ILLEGAL_EN
    output logic        illegal,
`endif
    output logic        dp_vld,
    input  logic        dp_rdy,
    output logic        rd_r0_vld,
    output logic [4:0]  rd_r0_addr,
    output logic        rd_r1_vld,
    output logic [4:0]  rd_r1_addr,
    output logic        wr_vld,
    output logic [4:0]  wr_addr,
    output logic [31:0] imm,
    output logic        use_imm,
    output logic        is_alu,
    output logic        is_mul,
    output logic        is_div,
    output logic [3:0]  alu_op,
    output logic [1:0]  mul_op,
    output logic [1:0]  div_op
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_XOR  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_NOP  = 4'h9;
    localparam logic [3:0] ALU_SLTU = 4'hA;

    typedef struct packed {
        logic        r0_vld;
        logic [4:0]  r0_addr;
        logic        r1_vld;
        logic [4:0]  r1_addr;
        logic        wr_vld;
        logic [4:0]  wr_addr;
        logic [31:0] imm;
        logic        use_imm;
        logic        is_alu;
        logic        is_mul;
        logic        is_div;
        logic [3:0]  alu_op;
        logic [1:0]  mul_op;
        logic [1:0]  div_op;
`ifdef PEAK_DPU_DE_DP_ILLEGAL_EN
        logic        illegal;
`endif
    } bundle_t;

    // funct3 -> ALU op for OP / OP-IMM (bit 30 variants handled by the caller)
    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        case (f3)
            3'd0:    f3_alu = ALU_ADD;
            3'd1:    f3_alu = ALU_SLL;
            3'd2:    f3_alu = ALU_SLT;
            3'd3:    f3_alu = ALU_SLTU;
            3'd4:    f3_alu = ALU_XOR;
            3'd5:    f3_alu = ALU_SRL;
            3'd6:    f3_alu = ALU_OR;
            default: f3_alu = ALU_AND;
        endcase
    endfunction

    // ---------------- instruction fields ----------------
    logic [4:0]  rd, rs1, rs2, crs2, crd_p, crs2_p;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] c_imm6, c_lui_imm, c_sp16_imm, c_4spn_imm, c_shamt;
    logic [31:0] i_imm, i_shamt, u_imm;

    assign rd         = in_op[11:7];
    assign rs1        = in_op[19:15];
    assign rs2        = in_op[24:20];
    assign crs2       = in_op[6:2];
    assign crd_p      = {2'b01, in_op[9:7]};   // primed fields select x8..x15
    assign crs2_p     = {2'b01, in_op[4:2]};
    assign funct3     = in_op[14:12];
    assign funct7     = in_op[31:25];
    assign c_imm6     = {{26{in_op[12]}}, in_op[12], in_op[6:2]};
    assign c_lui_imm  = {{14{in_op[12]}}, in_op[12], in_op[6:2], 12'h000};
    assign c_sp16_imm = {{22{in_op[12]}}, in_op[12], in_op[4:3], in_op[5], in_op[2], in_op[6], 4'h0};
    assign c_4spn_imm = {22'h0, in_op[10:7], in_op[12:11], in_op[5], in_op[6], 2'b00};
    assign c_shamt    = {26'h0, in_op[12], in_op[6:2]};
    assign i_imm      = {{20{in_op[31]}}, in_op[31:20]};
    assign i_shamt    = {27'h0, in_op[24:20]};
    assign u_imm      = {in_op[31:12], 12'h000};

    // ---------------- decode ----------------
    bundle_t dec;

    always_comb begin
        dec = '0;
        if (in_is_compressed) begin
            case ({in_op[15:13], in_op[1:0]})
                5'b000_00: begin // c.addi4spn
                    dec.is_alu  = 1'b1;
                    dec.r0_vld  = 1'b1;
                    dec.r0_addr = 5'd2;
                    dec.wr_addr = crs2_p;
                    dec.imm     = c_4spn_imm;
                    dec.use_imm = 1'b1;
                end
                5'b000_01: begin // c.addi / c.nop
                    dec.is_alu  = 1'b1;
                    dec.wr_addr = rd;
                    if (rd == 5'd0 && c_imm6 == 32'h0) begin
                        dec.alu_op = ALU_NOP;
                    end else begin
                        dec.r0_vld  = 1'b1;
                        dec.r0_addr = rd;
                        dec.imm     = c_imm6;
                        dec.use_imm = 1'b1;
                    end
                end
                5'b010_01: begin // c.li
                    dec.is_alu  = 1'b1;
                    dec.r0_vld  = 1'b1;
                    dec.wr_addr = rd;
                    dec.imm     = c_imm6;
                    dec.use_imm = 1'b1;
                end
                5'b011_01: begin // c.addi16sp wins over c.lui when rd==x2
                    dec.is_alu  = 1'b1;
                    dec.r0_vld  = 1'b1;
                    dec.wr_addr = rd;
                    dec.use_imm = 1'b1;
                    if (rd == 5'd2) begin
                        dec.r0_addr = 5'd2;
                        dec.imm     = c_sp16_imm;
                    end else begin
                        dec.imm     = c_lui_imm;
                    end
                end
                5'b100_01: begin // c.srli/c.srai/c.andi/c.sub/c.xor/c.or/c.and
                    case (in_op[11:10])
                        2'b00, 2'b01: begin
                            dec.is_alu  = 1'b1;
                            dec.r0_vld  = 1'b1;
                            dec.r0_addr = crd_p;
                            dec.wr_addr = crd_p;
                            dec.imm     = c_shamt;
                            dec.use_imm = 1'b1;
                            dec.alu_op  = in_op[10] ? ALU_SRA : ALU_SRL;
                        end
                        2'b10: begin
                            dec.is_alu  = 1'b1;
                            dec.r0_vld  = 1'b1;
                            dec.r0_addr = crd_p;
                            dec.wr_addr = crd_p;
                            dec.imm     = c_imm6;
                            dec.use_imm = 1'b1;
                            dec.alu_op  = ALU_AND;
                        end
                        default: begin
                            // op[12]=1 are RV64 word ops: not DP here
                            if (!in_op[12]) begin
                                dec.is_alu  = 1'b1;
                                dec.r0_vld  = 1'b1;
                                dec.r0_addr = crd_p;
                                dec.r1_vld  = 1'b1;
                                dec.r1_addr = crs2_p;
                                dec.wr_addr = crd_p;
                                case (in_op[6:5])
                                    2'b00:   dec.alu_op = ALU_SUB;
                                    2'b01:   dec.alu_op = ALU_XOR;
                                    2'b10:   dec.alu_op = ALU_OR;
                                    default: dec.alu_op = ALU_AND;
                                endcase
                            end
                        end
                    endcase
                end
                5'b000_10: begin // c.slli
                    dec.is_alu  = 1'b1;
                    dec.r0_vld  = 1'b1;
                    dec.r0_addr = rd;
                    dec.wr_addr = rd;
                    dec.imm     = c_shamt;
                    dec.use_imm = 1'b1;
                    dec.alu_op  = ALU_SLL;
                end
                5'b100_10: begin // c.mv / c.add; rs2==0 encodings are jumps/ebreak
                    if (crs2 != 5'd0) begin
                        dec.is_alu  = 1'b1;
                        dec.r0_vld  = 1'b1;
                        dec.r0_addr = in_op[12] ? rd : 5'd0;
                        dec.r1_vld  = 1'b1;
                        dec.r1_addr = crs2;
                        dec.wr_addr = rd;
                    end
                end
                default: ;
            endcase
        end else begin
            case (in_op[6:0])
                7'b0010011: begin // OP-IMM
                    dec.is_alu  = 1'b1;
                    dec.r0_vld  = 1'b1;
                    dec.r0_addr = rs1;
                    dec.wr_addr = rd;
                    dec.use_imm = 1'b1;
                    dec.imm     = i_imm;
                    dec.alu_op  = f3_alu(funct3);
                    if (funct3 == 3'd1 || funct3 == 3'd5) begin
                        dec.imm = i_shamt;
                        if (funct3 == 3'd5 && funct7 == 7'b0100000) begin
                            dec.alu_op = ALU_SRA;
                        end else if (funct7 != 7'd0) begin
                            dec = '0;
                        end
                    end
                end
                7'b0110011: begin // OP, and RV32M when enabled
                    dec.r0_vld  = 1'b1;
                    dec.r0_addr = rs1;
                    dec.r1_vld  = 1'b1;
                    dec.r1_addr = rs2;
                    dec.wr_addr = rd;
                    if (funct7 == 7'd0) begin
                        dec.is_alu = 1'b1;
                        dec.alu_op = f3_alu(funct3);
                    end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                        dec.is_alu = 1'b1;
                        dec.alu_op = ALU_SUB;
                    end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                        dec.is_alu = 1'b1;
                        dec.alu_op = ALU_SRA;
                    end else if (funct7 == 7'b0000001 && M_EXT != 0) begin
                        if (funct3[2]) begin
                            dec.is_div = 1'b1;
                            dec.div_op = funct3[1:0];
                        end else begin
                            dec.is_mul = 1'b1;
                            dec.mul_op = funct3[1:0];
                        end
                    end else begin
                        dec = '0;
                    end
                end
                7'b0110111: begin // LUI
                    dec.is_alu  = 1'b1;
                    dec.r0_vld  = 1'b1;
                    dec.wr_addr = rd;
                    dec.imm     = u_imm;
                    dec.use_imm = 1'b1;
                end
                default: ;
            endcase
        end

`ifdef PEAK_DPU_DE_DP_ILLEGAL_EN
        dec.illegal = (in_op == 32'h0) || (in_op == 32'hFFFF_FFFF) ||
                      (in_is_compressed && in_op[1:0] == 2'b00 && in_op[15:13] == 3'b000 &&
                       c_4spn_imm == 32'h0) ||
                      (in_is_compressed && in_op[1:0] == 2'b01 && in_op[15:13] == 3'b011 &&
                       rd != 5'd2 && c_lui_imm == 32'h0);
        if (dec.illegal) begin
            dec.is_alu = 1'b0;
            dec.is_mul = 1'b0;
            dec.is_div = 1'b0;
        end
`endif
        // x0 destinations still report a write; issue sorts that out
        dec.wr_vld = dec.is_alu | dec.is_mul | dec.is_div;
    end

    // ---------------- queue ----------------
    bundle_t        mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    logic           push, pop;

    assign in_rdy = (count != FULL);
    assign dp_vld = (count != '0);
    assign push   = in_vld & in_rdy;
    assign pop    = dp_vld & dp_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: the head is masked by dp_vld below.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= dec;
    end

    bundle_t head;
    assign head = dp_vld ? mem[rd_ptr] : '0;

    assign rd_r0_vld  = head.r0_vld;
    assign rd_r0_addr = head.r0_addr;
    assign rd_r1_vld  = head.r1_vld;
    assign rd_r1_addr = head.r1_addr;
    assign wr_vld     = head.wr_vld;
    assign wr_addr    = head.wr_addr;
    assign imm        = head.imm;
    assign use_imm    = head.use_imm;
    assign is_alu     = head.is_alu;
    assign is_mul     = head.is_mul;
    assign is_div     = head.is_div;
    assign alu_op     = head.alu_op;
    assign mul_op     = head.mul_op;
    assign div_op     = head.div_op;
`ifdef PEAK_DPU_DE_DP_ILLEGAL_EN
    assign illegal    = head.illegal;
`endif

endmodule
